// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
// Walks a frame in raster order. For each interior pixel it gathers the NxN
// neighbourhood from the frame buffer into the ALU window bus and writes the
// filtered result. Border pixels read only their centre and pass it through.
// The kernel and divisor banks are loaded from the config port while idle.
module conv_window_sequencer #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 48,
   parameter int N      = 3,
   parameter int DAT_W  = 12,
   parameter int K_W    = 5,
   parameter int DIV_W  = 3,
   parameter int ADDR_W = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   input  logic                       cfg_we,
   input  logic [$clog2(N*N)-1:0]     cfg_idx,
   input  logic [K_W-1:0]             cfg_k,
   input  logic                       cfg_div_we,
   input  logic [DIV_W-1:0]           cfg_div,
   output logic [ADDR_W-1:0]          rd_addr,
   output logic                       rd_en,
   input  logic [DAT_W-1:0]           rd_data,
   output logic [N*N*DAT_W-1:0]       alu_din,
   output logic [N*N*K_W-1:0]         alu_kernel,
   output logic [DIV_W-1:0]           alu_div,
   input  logic [DAT_W-1:0]           alu_dout,
   output logic                       wr_en,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DAT_W-1:0]           wr_data
);

   localparam int NN     = N * N;
   localparam int IDX_W  = $clog2(NN);
   localparam int X_W    = $clog2(IMG_W);
   localparam int Y_W    = $clog2(IMG_H);
   localparam int D_W    = $clog2(N + 1);
   localparam int HALF   = N / 2;
   localparam int CENTRE = NN / 2;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_WRITE, S_DONE} state_t;

   state_t             state_reg, state_next;
   logic [X_W-1:0]     x_reg, x_next;
   logic [Y_W-1:0]     y_reg, y_next;
   logic [D_W-1:0]     dx_reg, dx_next;
   logic [D_W-1:0]     dy_reg, dy_next;
   logic               border_cur, border_next;
   logic [ADDR_W-1:0]  centre_addr, rd_addr_next;
   logic [IDX_W-1:0]   rd_k_next;

   logic               rd_en_reg, wr_en_reg, busy_reg, done_reg;
   logic [ADDR_W-1:0]  rd_addr_reg, wr_addr_reg;
   logic [IDX_W-1:0]   rd_k_reg, pend_k_reg;
   logic               pend_reg, wr_border_reg;
   logic [DIV_W-1:0]   div_reg;

   // Border pixels have no full neighbourhood inside the frame.
   function automatic logic is_border(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
      return (px < X_W'(HALF)) || (py < Y_W'(HALF)) ||
             (px >= X_W'(IMG_W - HALF)) || (py >= Y_W'(IMG_H - HALF));
   endfunction

   assign border_cur = is_border(x_reg, y_reg);

   // Next-state: one read per FETCH cycle, then capture, write and advance.
   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      dx_next    = dx_reg;
      dy_next    = dy_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_FETCH;
               x_next     = '0;
               y_next     = '0;
               dx_next    = '0;
               dy_next    = '0;
            end
         end
         S_FETCH: begin
            if (border_cur || (dx_reg == D_W'(N - 1) && dy_reg == D_W'(N - 1))) begin
               state_next = S_CAPTURE;
            end else if (dx_reg == D_W'(N - 1)) begin
               dx_next = '0;
               dy_next = dy_reg + D_W'(1);
            end else begin
               dx_next = dx_reg + D_W'(1);
            end
         end
         S_CAPTURE: state_next = S_WRITE;
         S_WRITE: begin
            dx_next = '0;
            dy_next = '0;
            if (x_reg == X_W'(IMG_W - 1) && y_reg == Y_W'(IMG_H - 1)) begin
               state_next = S_DONE;
            end else begin
               state_next = S_FETCH;
               if (x_reg == X_W'(IMG_W - 1)) begin
                  x_next = '0;
                  y_next = y_reg + Y_W'(1);
               end else begin
                  x_next = x_reg + X_W'(1);
               end
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Read address and window slot for the read issued in the next cycle.
   always_comb begin
      border_next  = is_border(x_next, y_next);
      centre_addr  = ADDR_W'(y_next) * ADDR_W'(IMG_W) + ADDR_W'(x_next);
      rd_addr_next = centre_addr;
      rd_k_next    = IDX_W'(CENTRE);
      if (!border_next) begin
         rd_addr_next = centre_addr + ADDR_W'(dy_next) * ADDR_W'(IMG_W) + ADDR_W'(dx_next)
                        - ADDR_W'(HALF * (IMG_W + 1));
         rd_k_next    = IDX_W'(dy_next) * IDX_W'(N) + IDX_W'(dx_next);
      end
   end

   // State, counters and registered strobes, all decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         x_reg         <= '0;
         y_reg         <= '0;
         dx_reg        <= '0;
         dy_reg        <= '0;
         rd_en_reg     <= 1'b0;
         rd_addr_reg   <= '0;
         rd_k_reg      <= '0;
         pend_reg      <= 1'b0;
         pend_k_reg    <= '0;
         wr_en_reg     <= 1'b0;
         wr_addr_reg   <= '0;
         wr_border_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg  <= state_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
         dx_reg     <= dx_next;
         dy_reg     <= dy_next;
         rd_en_reg  <= (state_next == S_FETCH);
         if (state_next == S_FETCH) begin
            rd_addr_reg <= rd_addr_next;
            rd_k_reg    <= rd_k_next;
         end
         // Data for the read visible this cycle returns next cycle.
         pend_reg   <= rd_en_reg;
         pend_k_reg <= rd_k_reg;
         wr_en_reg  <= (state_next == S_WRITE);
         if (state_next == S_WRITE) begin
            wr_addr_reg   <= centre_addr;
            wr_border_reg <= border_next;
         end
         busy_reg <= (state_next == S_FETCH) || (state_next == S_CAPTURE) ||
                     (state_next == S_WRITE);
         done_reg <= (state_next == S_DONE);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NN; gi++) begin : g_slice
         logic [DAT_W-1:0] win_q;
         logic [K_W-1:0]   kern_q;

         // Window slot gi takes the returning read that was aimed at it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               win_q <= '0;
            end else if (pend_reg && pend_k_reg == IDX_W'(gi)) begin
               win_q <= rd_data;
            end
         end

         // Kernel coefficient gi is writable only while idle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               kern_q <= '0;
            end else if (state_reg == S_IDLE && cfg_we && cfg_idx == IDX_W'(gi)) begin
               kern_q <= cfg_k;
            end
         end

         assign alu_din[gi*DAT_W +: DAT_W] = win_q;
         assign alu_kernel[gi*K_W +: K_W]  = kern_q;
      end
   endgenerate

   // Divisor is writable only while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg <= '0;
      end else if (state_reg == S_IDLE && cfg_div_we) begin
         div_reg <= cfg_div;
      end
   end

   assign alu_div = div_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign rd_en   = rd_en_reg;
   assign rd_addr = rd_addr_reg;
   assign wr_en   = wr_en_reg;
   assign wr_addr = wr_addr_reg;
   // The window is complete only from the WRITE cycle, so the ALU result is
   // steered straight to the output there; outside a write the bus reads zero.
   assign wr_data = wr_en_reg ? (wr_border_reg ? alu_din[CENTRE*DAT_W +: DAT_W] : alu_dout)
                              : '0;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer on a 4x4 frame with a 3x3 window.
// The stimulus side pushes the expected writes (and the reads each pixel should
// issue) into queues; a negedge monitor pops and compares on every wr_en.
module tb_conv_window_sequencer;
   localparam int W = 4, H = 4, N = 3, NN = 9, DW = 12, KW = 5, DVW = 3, AW = 12;
   localparam int NPIX = W * H;

   logic clk, rst_n, start, busy, done, cfg_we, cfg_div_we, rd_en, wr_en;
   logic [3:0] cfg_idx;
   logic [KW-1:0] cfg_k;
   logic [DVW-1:0] cfg_div, alu_div;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] rd_data, alu_dout, wr_data;
   logic [NN*DW-1:0] alu_din;
   logic [NN*KW-1:0] alu_kernel;

   conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .N(N), .DAT_W(DW), .K_W(KW),
                           .DIV_W(DVW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_k(cfg_k), .cfg_div_we(cfg_div_we),
      .cfg_div(cfg_div), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
      .alu_din(alu_din), .alu_kernel(alu_kernel), .alu_div(alu_div),
      .alu_dout(alu_dout), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   int total = 0, bad = 0, cyc = 0, last_rd_cyc = 0, wr_seen = 0;
   logic [DW-1:0] frame [NPIX];
   logic [NN*KW-1:0] kmodel = '0;
   logic [DVW-1:0] divm = '0;
   logic [AW-1:0] exp_addr_q[$], exp_rd_q[$], obs_rd_q[$];
   logic [DW-1:0] exp_data_q[$];
   int exp_nrd_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Filter applied per 4-bit colour channel: signed MAC, arithmetic shift, clamp.
   function automatic logic [DW-1:0] filt(input logic [NN*DW-1:0] pw,
                                          input logic [NN*KW-1:0] kw, input logic [DVW-1:0] dv);
      logic [DW-1:0] r;
      int acc;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         acc = 0;
         for (int i = 0; i < NN; i++)
            acc += int'(pw[i*DW + c*4 +: 4]) * int'($signed(kw[i*KW +: KW]));
         acc = acc >>> dv;
         if (acc < 0) acc = 0;
         if (acc > 15) acc = 15;
         r[c*4 +: 4] = acc[3:0];
      end
      return r;
   endfunction

   // Frame buffer: synchronous read, one cycle latency.
   always @(posedge clk) if (rd_en) rd_data <= frame[rd_addr[3:0]];
   // Shared ALU is combinational on the sequencer's window and config buses.
   always_comb alu_dout = filt(alu_din, alu_kernel, alu_div);

   // Monitor: collect reads, and on each write pop the scoreboard and compare.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_en) begin
            obs_rd_q.push_back(rd_addr);
            last_rd_cyc = cyc;
         end
         if (wr_en) begin
            wr_seen++;
            chk("rd_wr_exclusive", 64'(rd_en), 64'd0);
            chk("write_expected", 64'(exp_addr_q.size() > 0), 64'd1);
            if (exp_addr_q.size() > 0) begin
               int n;
               logic [AW-1:0] er;
               chk("wr_addr", 64'(wr_addr), 64'(exp_addr_q.pop_front()));
               chk("wr_data", 64'(wr_data), 64'(exp_data_q.pop_front()));
               n = exp_nrd_q.pop_front();
               chk("rd_count", 64'(obs_rd_q.size()), 64'(n));
               for (int i = 0; i < n; i++) begin
                  er = exp_rd_q.pop_front();
                  if (i < obs_rd_q.size()) chk("rd_addr_seq", 64'(obs_rd_q[i]), 64'(er));
               end
               chk("rd_to_wr_gap", 64'(cyc - last_rd_cyc), 64'd2);
            end
            obs_rd_q.delete();
         end
      end
   end

   task automatic clear_sb();
      exp_addr_q.delete(); exp_data_q.delete(); exp_nrd_q.delete();
      exp_rd_q.delete(); obs_rd_q.delete();
   endtask

   // Reference: raster walk; interior pixels filter their neighbourhood,
   // border pixels copy the centre. Returns the expected start-to-done cycles.
   task automatic build_expected(output int lat);
      logic [NN*DW-1:0] pw;
      lat = 1;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            exp_addr_q.push_back(AW'(y*W + x));
            if (x < N/2 || y < N/2 || x >= W - N/2 || y >= H - N/2) begin
               exp_data_q.push_back(frame[y*W + x]);
               exp_nrd_q.push_back(1);
               exp_rd_q.push_back(AW'(y*W + x));
               lat += 3;
            end else begin
               for (int dy = 0; dy < N; dy++)
                  for (int dx = 0; dx < N; dx++) begin
                     pw[(dy*N + dx)*DW +: DW] = frame[(y+dy-N/2)*W + x+dx-N/2];
                     exp_rd_q.push_back(AW'((y+dy-N/2)*W + x+dx-N/2));
                  end
               exp_data_q.push_back(filt(pw, kmodel, divm));
               exp_nrd_q.push_back(NN);
               lat += NN + 2;
            end
         end
      end
   endtask

   task automatic load_cfg(input logic [NN*KW-1:0] kv, input logic [DVW-1:0] dv);
      for (int i = 0; i < NN; i++) begin
         @(posedge clk); #1;
         cfg_we = 1'b1; cfg_idx = 4'(i); cfg_k = kv[i*KW +: KW];
      end
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_div_we = 1'b1; cfg_div = dv;
      @(posedge clk); #1;
      cfg_div_we = 1'b0;
      kmodel = kv; divm = dv;
      @(negedge clk);
      chk("cfg_kernel", 64'(alu_kernel), 64'(kmodel));
      chk("cfg_div", 64'(alu_div), 64'(divm));
   endtask

   task automatic run_frame(input bit disturb);
      int lat, cycles, base;
      bit got;
      build_expected(lat);
      base = wr_seen; cycles = 0; got = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (cycles < 2000 && !got) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) chk("busy_after_start", 64'(busy), 64'd1);
         if (disturb && cycles == 20) begin
            start = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd0; cfg_k = 5'h1F;
         end
         if (disturb && cycles == 21) begin
            start = 1'b0; cfg_we = 1'b0;
         end
         if (done) got = 1'b1;
      end
      chk("done_seen", 64'(got), 64'd1);
      chk("done_latency", 64'(cycles), 64'(lat));
      chk("busy_at_done", 64'(busy), 64'd0);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("writes_in_frame", 64'(wr_seen - base), 64'(NPIX));
      chk("scoreboard_drained", 64'(exp_addr_q.size()), 64'd0);
      if (disturb) chk("kernel_kept", 64'(alu_kernel), 64'(kmodel));
      repeat (3) @(negedge clk);
      chk("no_restart", 64'(busy), 64'd0);
      clear_sb();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, ws;
      logic [NN*KW-1:0] kv;
      rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_div_we = 1'b0;
      cfg_idx = '0; cfg_k = '0; cfg_div = '0;
      for (int i = 0; i < NPIX; i++) frame[i] = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_rd_addr", 64'(rd_addr), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_alu_din", 64'(alu_din != '0), 64'd0);
      chk("rst_kernel", 64'(alu_kernel), 64'd0);
      chk("rst_div", 64'(alu_div), 64'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_no_write", 64'(wr_seen), 64'd0);
      chk("idle_no_read", 64'(obs_rd_q.size()), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      // Identity kernel on a ramp frame: output equals input.
      for (int i = 0; i < NPIX; i++) frame[i] = DW'(i);
      kv = '0; kv[4*KW +: KW] = 5'd1;
      load_cfg(kv, 3'd0);
      run_frame(1'b0);

      // Box kernel, shift 3, constant 0x222.
      for (int i = 0; i < NPIX; i++) frame[i] = 12'h222;
      for (int i = 0; i < NN; i++) kv[i*KW +: KW] = 5'd1;
      load_cfg(kv, 3'd3);
      run_frame(1'b0);

      // Start and config writes while busy are ignored.
      for (int i = 0; i < NPIX; i++) frame[i] = DW'($urandom);
      run_frame(1'b1);

      // Reset during the first fetch cycle of pixel (1,1).
      build_expected(lat);
      ws = wr_seen;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 500 && wr_seen < ws + 5; i++) begin
         @(negedge clk); #1;
      end
      chk("reached_pixel_1_1", 64'(wr_seen - ws), 64'd5);
      @(posedge clk); #2;
      chk("fetch_1_1_rd_en", 64'(rd_en), 64'd1);
      chk("fetch_1_1_rd_addr", 64'(rd_addr), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_wr_en", 64'(wr_en), 64'd0);
      chk("abort_rd_en", 64'(rd_en), 64'd0);
      chk("abort_kernel", 64'(alu_kernel), 64'd0);
      chk("abort_div", 64'(alu_div), 64'd0);
      kmodel = '0; divm = '0;
      clear_sb();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ws = wr_seen;
      repeat (5) @(negedge clk);
      chk("abort_no_write", 64'(wr_seen - ws), 64'd0);
      run_frame(1'b0);

      // Randomised kernels, divisors and frames.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < NPIX; i++) frame[i] = DW'($urandom);
         for (int i = 0; i < NN; i++) kv[i*KW +: KW] = KW'($urandom_range(0, 8) - 4);
         load_cfg(kv, DVW'($urandom_range(0, 7)));
         run_frame(it == 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
